// File: rtl/cell_delay_sequencer_if.sv
// Bus between the delay sequencer and its characterisation harness.
// Carries the cell stimulus and response, the request/result handshake, and a debug view of the FSM state.
interface cell_delay_sequencer_if #(
    parameter int CNT_W = 8
);
    // Handshake: START is a level request that is taken only while idle,
    // and INVERT is captured with it. BUSY rises on the following cycle.
    // DONE pulses for one cycle when ERR, RISE_CNT and FALL_CNT are valid,
    // and those values hold until the next accepted START.
    logic             START;
    logic             INVERT;
    logic             Y_DUT;
    logic             A_DUT;
    logic             BUSY;
    logic             DONE;
    logic             ERR;
    logic [CNT_W-1:0] RISE_CNT;
    logic [CNT_W-1:0] FALL_CNT;
    logic [2:0]       dbg_state;

    modport master (
        output START, INVERT, Y_DUT,
        input  A_DUT, BUSY, DONE, ERR, RISE_CNT, FALL_CNT, dbg_state
    );

    modport slave (
        input  START, INVERT, Y_DUT,
        output A_DUT, BUSY, DONE, ERR, RISE_CNT, FALL_CNT, dbg_state
    );
endinterface

// File: rtl/cell_delay_sequencer.sv
// Measures a cell's rise and fall propagation delay in clock cycles.
// The cell is driven through A_DUT, and its output Y_DUT is observed through a two-flop synchroniser.
module cell_delay_sequencer #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200,
    parameter int SETTLE  = 4
) (
    input logic                    C,
    input logic                    R,
    cell_delay_sequencer_if.slave  bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETTLE_LO = 3'd1;
    localparam logic [2:0] WAIT_RISE = 3'd2;
    localparam logic [2:0] WAIT_FALL = 3'd3;
    localparam logic [2:0] REPORT    = 3'd4;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ERR_CODE    = '1;
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rise_q, rise_d;
    logic [CNT_W-1:0] fall_q, fall_d;
    logic             inv_q, inv_d;
    logic             a_q, a_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             s1_q, s2_q;
    logic             exp_lo, exp_hi;

    assign exp_lo = inv_q;
    assign exp_hi = ~inv_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        inv_d   = inv_q;
        a_d     = a_q;
        busy_d  = busy_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    inv_d   = bus.INVERT;
                    err_d   = 1'b0;
                    rise_d  = '0;
                    fall_d  = '0;
                    cnt_d   = '0;
                    a_d     = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETTLE_LO;
                end
            end
            SETTLE_LO: begin
                a_d = 1'b0;
                if (cnt_q == SETTLE_LAST) begin
                    // A response already at the launch level means the cell is stuck.
                    if (s2_q != exp_lo) begin
                        err_d   = 1'b1;
                        rise_d  = ERR_CODE;
                        fall_d  = ERR_CODE;
                        state_d = REPORT;
                    end else begin
                        a_d     = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_RISE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            WAIT_RISE: begin
                if (s2_q == exp_hi) begin
                    rise_d  = cnt_q;
                    a_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_FALL;
                end else if (cnt_q == TIMEOUT_C) begin
                    err_d   = 1'b1;
                    rise_d  = ERR_CODE;
                    fall_d  = ERR_CODE;
                    a_d     = 1'b0;
                    state_d = REPORT;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            WAIT_FALL: begin
                if (s2_q == exp_lo) begin
                    fall_d  = cnt_q;
                    state_d = REPORT;
                end else if (cnt_q == TIMEOUT_C) begin
                    // The rise result is kept so a fall-only failure stays diagnosable.
                    err_d   = 1'b1;
                    fall_d  = ERR_CODE;
                    state_d = REPORT;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            REPORT: begin
                busy_d  = 1'b0;
                a_d     = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                a_d     = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            inv_q   <= 1'b0;
            a_q     <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            inv_q   <= inv_d;
            a_q     <= a_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            s1_q    <= bus.Y_DUT;
            s2_q    <= s1_q;
        end
    end

    assign bus.A_DUT     = a_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = (state_q == REPORT);
    assign bus.ERR       = err_q;
    assign bus.RISE_CNT  = rise_q;
    assign bus.FALL_CNT  = fall_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_cell_delay_sequencer.sv
// Directed bench for cell_delay_sequencer: ideal buffer, delayed inverter, stuck and timeout cells,
// mid-measurement reset, and back-to-back requests.
module tb_cell_delay_sequencer;
  localparam int CNT_W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cell_delay_sequencer_if #(.CNT_W(CNT_W)) bus ();

  cell_delay_sequencer #(.CNT_W(CNT_W), .TIMEOUT(200), .SETTLE(4)) dut (
    .C   (clk),
    .R   (rst),
    .bus (bus)
  );

  // cell model: 0 = ideal BUF, 1 = NOT delayed 3 cycles, 2 = tied 0, 3 = tied 1
  int         y_mode = 0;
  logic [3:0] a_hist;
  always @(posedge clk) begin
    if (rst) a_hist <= '0;
    else     a_hist <= {a_hist[2:0], bus.A_DUT};
  end
  always_comb begin
    case (y_mode)
      0:       bus.Y_DUT = bus.A_DUT;
      1:       bus.Y_DUT = ~a_hist[2];
      2:       bus.Y_DUT = 1'b0;
      default: bus.Y_DUT = 1'b1;
    endcase
  end

  int done_cnt = 0;
  always @(posedge clk) begin
    if (!rst && bus.DONE) done_cnt <= done_cnt + 1;
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edge 0 is the clock edge that accepts START; done_edge is the edge after which DONE is seen high.
  task automatic measure(input logic inv, output int done_edge, output logic a_rose);
    bus.INVERT = inv;
    bus.START  = 1'b1;
    step();
    bus.START  = 1'b0;
    bus.INVERT = 1'b0;
    check("busy_after_start", {31'd0, bus.BUSY}, 32'd1);
    done_edge = -1;
    a_rose    = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      step();
      if (bus.A_DUT) a_rose = 1'b1;
      if (bus.START === 1'b0 && n == 3) begin
        bus.START = 1'b1;   // ignored: FSM is busy
        step();
        bus.START = 1'b0;
        n++;
        if (bus.A_DUT) a_rose = 1'b1;
        if (bus.DONE) begin done_edge = n; break; end
      end
      if (bus.DONE) begin done_edge = n; break; end
    end
    check("done_seen", {31'd0, done_edge > 0}, 32'd1);
  endtask

  task automatic after_done(input string tag, input int dc_before);
    step();
    check({tag, "_done_low"}, {31'd0, bus.DONE}, 32'd0);
    check({tag, "_busy_low"}, {31'd0, bus.BUSY}, 32'd0);
    check({tag, "_done_once"}, done_cnt - dc_before, 32'd1);
    step();
  endtask

  int   de;
  logic ar;
  int   dc0;

  initial begin
    bus.START  = 1'b0;
    bus.INVERT = 1'b0;
    repeat (3) step();
    check("rst_a", {31'd0, bus.A_DUT}, 32'd0);
    check("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    check("rst_done", {31'd0, bus.DONE}, 32'd0);
    check("rst_err", {31'd0, bus.ERR}, 32'd0);
    check("rst_rise", {24'd0, bus.RISE_CNT}, 32'd0);
    check("rst_fall", {24'd0, bus.FALL_CNT}, 32'd0);
    check("rst_state", {29'd0, bus.dbg_state}, 32'd0);
    rst = 1'b0;
    step();

    // 1: ideal BUF. Settle edges 1..4, rise detected at edge 7, fall at edge 10, DONE after edge 10.
    y_mode = 0;
    dc0 = done_cnt;
    measure(1'b0, de, ar);
    check("buf_done_edge", de, 32'd10);
    check("buf_busy_in_report", {31'd0, bus.BUSY}, 32'd1);
    check("buf_rise", {24'd0, bus.RISE_CNT}, 32'd2);
    check("buf_fall", {24'd0, bus.FALL_CNT}, 32'd2);
    check("buf_err", {31'd0, bus.ERR}, 32'd0);
    after_done("buf", dc0);
    check("buf_hold_rise", {24'd0, bus.RISE_CNT}, 32'd2);

    // 2: inverter with 3-cycle delay -> 3 + 2 on each edge; rise at edge 10, fall at edge 16.
    y_mode = 1;
    dc0 = done_cnt;
    measure(1'b1, de, ar);
    check("not_done_edge", de, 32'd16);
    check("not_rise", {24'd0, bus.RISE_CNT}, 32'd5);
    check("not_fall", {24'd0, bus.FALL_CNT}, 32'd5);
    check("not_err", {31'd0, bus.ERR}, 32'd0);
    after_done("not", dc0);

    // 3: output tied low -> counter reaches 200 at edge 204, timeout taken at edge 205.
    y_mode = 2;
    dc0 = done_cnt;
    measure(1'b0, de, ar);
    check("to_done_edge", de, 32'd205);
    check("to_err", {31'd0, bus.ERR}, 32'd1);
    check("to_rise", {24'd0, bus.RISE_CNT}, 32'hFF);
    check("to_fall", {24'd0, bus.FALL_CNT}, 32'hFF);
    check("to_a_low", {31'd0, bus.A_DUT}, 32'd0);
    after_done("to", dc0);
    check("to_err_sticky", {31'd0, bus.ERR}, 32'd1);

    // 4: output tied high -> stuck detected on the last settle edge (edge 4).
    y_mode = 3;
    dc0 = done_cnt;
    measure(1'b0, de, ar);
    check("stuck_done_edge", de, 32'd4);
    check("stuck_a_never_rose", {31'd0, ar}, 32'd0);
    check("stuck_err", {31'd0, bus.ERR}, 32'd1);
    check("stuck_rise", {24'd0, bus.RISE_CNT}, 32'hFF);
    check("stuck_fall", {24'd0, bus.FALL_CNT}, 32'hFF);
    after_done("stuck", dc0);

    // 5: reset while waiting for the rise.
    y_mode = 2;
    dc0 = done_cnt;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    repeat (5) step();
    check("mid_state_wait_rise", {29'd0, bus.dbg_state}, 32'd2);
    check("mid_a_high", {31'd0, bus.A_DUT}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_state", {29'd0, bus.dbg_state}, 32'd0);
    check("mid_rst_a", {31'd0, bus.A_DUT}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.BUSY}, 32'd0);
    check("mid_rst_rise", {24'd0, bus.RISE_CNT}, 32'd0);
    check("mid_rst_fall", {24'd0, bus.FALL_CNT}, 32'd0);
    repeat (3) step();
    check("mid_rst_no_done", done_cnt - dc0, 32'd0);
    y_mode = 0;
    dc0 = done_cnt;
    measure(1'b0, de, ar);
    check("post_rst_rise", {24'd0, bus.RISE_CNT}, 32'd2);
    check("post_rst_fall", {24'd0, bus.FALL_CNT}, 32'd2);
    after_done("post_rst", dc0);

    // 6: START held for 40 edges. Each run takes 10 edges to DONE, 1 back to IDLE, 1 to re-accept.
    y_mode = 0;
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd22);
    exp_q.push_back(32'd34);
    exp_q.push_back(32'd46);
    bus.START = 1'b1;
    for (int n = 0; n < 60; n++) begin
      step();
      if (n == 39) bus.START = 1'b0;
      if (bus.DONE) begin
        if (exp_q.size() > 0) check("b2b_done_edge", n, exp_q.pop_front());
        else                  check("b2b_extra_done", n, 32'hFFFF_FFFF);
        check("b2b_rise", {24'd0, bus.RISE_CNT}, 32'd2);
        check("b2b_fall", {24'd0, bus.FALL_CNT}, 32'd2);
      end
    end
    check("b2b_all_done", exp_q.size(), 32'd0);
    check("b2b_idle", {29'd0, bus.dbg_state}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
